// File: rtl/axi_wr_seq_pkg.sv
// Shared types and constants for the AXI write burst sequencer.
package axi_wr_seq_pkg;

  localparam int ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ADDR = 3'b001,
    ST_DATA = 3'b010,
    ST_RESP = 3'b011,
    ST_DONE = 3'b100
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_rsp_t;

  // Anything but OKAY, or a response tagged for another requester, is an error.
  function automatic logic b_is_err(input b_rsp_t rsp, input logic [ID_W-1:0] exp_id);
    return (rsp.resp != BRESP_OKAY) || (rsp.id != exp_id);
  endfunction

endpackage

// File: rtl/axi_write_burst_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_arbiter
  import axi_wr_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    idx
);

  logic found;

  // Pass 1 covers indices at/above the pointer, pass 2 the wrapped-around ones.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PW'(i) >= rr_ptr)) begin
        winner[i] = 1'b1;
        idx       = ID_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        winner[i] = 1'b1;
        idx       = ID_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_burst_sequencer.sv
// Shares one AXI write path between NUM_REQ requesters, one burst outstanding.
// Optional B-response watchdog enabled by defining AXI_WR_SEQ_TIMEOUT_EN.
module axi_write_burst_sequencer
  import axi_wr_seq_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_BYTES_LOG2 = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [ID_W-1:0]               AWID,
  output logic [ADDR_WIDTH-1:0]         AWADDR,
  output logic [7:0]                    AWLEN,
  output logic [2:0]                    AWSIZE,
  output logic [1:0]                    AWBURST,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic                          dc_go,
  output logic [ID_W-1:0]               dc_transaction_ID,
  output logic                          dc_last_transfer,
  input  logic                          dc_data_sent,
  input  logic                          dc_done,
  input  logic [ID_W-1:0]               BID,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY,
  output logic [2:0]                    state_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_state_e state, state_nxt;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner_ptr, ptr_inc;
  logic [7:0]         beat_cnt;
  logic               err;
  logic               done_pulse;
  logic               to_hit;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic [PW-1:0]      win_sel;
  b_rsp_t             b_rsp;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][7:0]            len_arr;

  assign addr_arr = req_addr;
  assign len_arr  = req_len;
  assign b_rsp    = '{id: BID, resp: BRESP};
  assign win_sel  = win_idx[PW-1:0];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (win_oh),
    .idx    (win_idx)
  );

`ifdef AXI_WR_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Held at zero outside RESP, so it is clear on every RESP entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                to_cnt <= '0;
    else if (state != ST_RESP)  to_cnt <= '0;
    else if (!BVALID)           to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit = (state == ST_RESP) && !BVALID && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req)              state_nxt = ST_ADDR;
      ST_ADDR: if (AWREADY)           state_nxt = ST_DATA;
      ST_DATA: if (dc_done)           state_nxt = ST_RESP;
      ST_RESP: if (BVALID || to_hit)  state_nxt = ST_DONE;
      ST_DONE: if (!dc_done)          state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  assign owner_ptr = AWID[PW-1:0];
  assign ptr_inc   = (owner_ptr == PW'(NUM_REQ - 1)) ? '0 : owner_ptr + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= '0;
      AWID       <= '0;
      AWADDR     <= '0;
      AWLEN      <= '0;
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      err        <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: if (|req) begin
          grant    <= win_oh;
          AWID     <= win_idx;
          AWADDR   <= addr_arr[win_sel];
          AWLEN    <= len_arr[win_sel];
          beat_cnt <= '0;
          err      <= 1'b0;
        end
        ST_DATA: if (dc_data_sent) beat_cnt <= beat_cnt + 8'd1;
        ST_RESP: if (BVALID || to_hit) begin
          err        <= BVALID ? b_is_err(b_rsp, AWID) : 1'b1;
          done_pulse <= 1'b1;
          grant      <= '0;
          rr_ptr     <= ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // done_pulse is only set on the RESP->DONE edge, so req_done is an entry-cycle pulse.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_done
    assign req_done[i] = done_pulse && (AWID == ID_W'(i));
  end

  assign req_err           = done_pulse && err;
  assign AWSIZE            = 3'(DATA_BYTES_LOG2);
  assign AWBURST           = AXI_BURST_INCR;
  assign AWVALID           = (state == ST_ADDR);
  assign BREADY            = (state == ST_RESP);
  assign dc_go             = (state == ST_DATA) || (state == ST_RESP);
  assign dc_transaction_ID = AWID;
  assign dc_last_transfer  = (state == ST_DATA) && (beat_cnt == AWLEN);
  assign state_out         = state;

endmodule

// File: tb/tb_axi_write_burst_sequencer.sv
// Randomized directed bench for axi_write_burst_sequencer with a burst-level reference model.
module tb_axi_write_burst_sequencer;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    grant, req_done;
  logic            req_err;
  logic [3:0]      AWID;
  logic [AW-1:0]   AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID, AWREADY;
  logic            dc_go, dc_last_transfer, dc_data_sent, dc_done;
  logic [3:0]      dc_transaction_ID;
  logic [3:0]      BID;
  logic [1:0]      BRESP;
  logic            BVALID, BREADY;
  logic [2:0]      state_out;

  always #5 clk = ~clk;

  axi_write_burst_sequencer #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_BYTES_LOG2(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_addr(req_addr), .req_len(req_len),
    .grant(grant), .req_done(req_done), .req_err(req_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .dc_go(dc_go), .dc_transaction_ID(dc_transaction_ID), .dc_last_transfer(dc_last_transfer),
    .dc_data_sent(dc_data_sent), .dc_done(dc_done),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .state_out(state_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int rr_next = 0;
  logic [AW-1:0] m_addr [N];
  logic [7:0]    m_len  [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = m_addr[i];
      req_len[i*8 +: 8]    = m_len[i];
    end
  endtask

  // Reference arbitration: first asserted requester scanning cyclically from rr_next.
  function automatic int rr_pick(input logic [N-1:0] rq);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr_next + k) % N;
      if (rq[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_err"}, req_err, 0);
    chk({tag, "_awid"}, AWID, 0);
    chk({tag, "_awaddr"}, AWADDR, 0);
    chk({tag, "_awlen"}, AWLEN, 0);
    chk({tag, "_awvalid"}, AWVALID, 0);
    chk({tag, "_go"}, dc_go, 0);
    chk({tag, "_last"}, dc_last_transfer, 0);
    chk({tag, "_dcid"}, dc_transaction_ID, 0);
    chk({tag, "_bready"}, BREADY, 0);
    chk({tag, "_state"}, state_out, 0);
    chk({tag, "_awsize"}, AWSIZE, 3'd2);
    chk({tag, "_awburst"}, AWBURST, 2'b01);
  endtask

  // Drives one full burst as the AW slave, data-channel block and B slave.
  // bid < 0 means answer with the owner's ID.
  task automatic run_burst(input logic [N-1:0] rq, input int aw_delay, input int b_delay,
                           input int bid, input logic [1:0] bresp, input bit drop_req,
                           input int done_hold, input bit no_b);
    int own;
    logic [N-1:0] oh;
    logic [AW-1:0] ea;
    logic [7:0] el;
    logic [3:0] b;
    logic exp_err;
    own = rr_pick(rq);
    oh = '0;
    oh[own] = 1'b1;
    ea = m_addr[own];
    el = m_len[own];
    req = rq;
    pack();
    step();
    chk("aw_grant", grant, oh);
    chk("aw_state", state_out, 3'b001);
    chk("aw_valid", AWVALID, 1);
    chk("aw_id", AWID, own);
    chk("aw_addr", AWADDR, ea);
    chk("aw_len", AWLEN, el);
    chk("aw_go", dc_go, 0);
    AWREADY = 1'b0;
    for (int d = 0; d < aw_delay; d++) begin
      step();
      chk("aw_hold_valid", AWVALID, 1);
      chk("aw_hold_addr", AWADDR, ea);
      chk("aw_hold_len", AWLEN, el);
      chk("aw_hold_id", AWID, own);
    end
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    chk("data_state", state_out, 3'b010);
    chk("data_go", dc_go, 1);
    chk("data_awvalid", AWVALID, 0);
    chk("data_dcid", dc_transaction_ID, own);
    if (drop_req) req = '0;
    for (int bt = 0; bt <= int'(el); bt++) begin
      if ($urandom_range(0, 3) == 0) step();
      chk("beat_last", dc_last_transfer, (bt == int'(el)));
      dc_data_sent = 1'b1;
      step();
      dc_data_sent = 1'b0;
    end
    dc_done = 1'b1;
    step();
    dc_done = 1'b0;
    chk("resp_state", state_out, 3'b011);
    chk("resp_bready", BREADY, 1);
    chk("resp_go", dc_go, 1);
    if (no_b) begin
`ifdef AXI_WR_SEQ_TIMEOUT_EN
      for (int c = 1; c < TO; c++) begin
        step();
        chk("to_wait_done", req_done, 0);
      end
      step();
      exp_err = 1'b1;
`endif
    end else begin
      for (int d = 0; d < b_delay; d++) begin
        step();
        chk("bwait_bready", BREADY, 1);
        chk("bwait_done", req_done, 0);
      end
      b = (bid < 0) ? 4'(own) : 4'(bid);
      BID = b;
      BRESP = bresp;
      BVALID = 1'b1;
      step();
      BVALID = 1'b0;
      BID = '0;
      BRESP = '0;
      exp_err = (bresp != 2'b00) || (b != 4'(own));
    end
    chk("done_pulse", req_done, oh);
    chk("done_err", req_err, exp_err);
    chk("done_grant", grant, 0);
    chk("done_go", dc_go, 0);
    chk("done_bready", BREADY, 0);
    chk("done_state", state_out, 3'b100);
    rr_next = (own + 1) % N;
    dc_done = (done_hold > 0);
    for (int h = 0; h < done_hold; h++) begin
      step();
      chk("hold_state", state_out, 3'b100);
      chk("hold_done", req_done, 0);
    end
    dc_done = 1'b0;
    step();
    chk("idle_state", state_out, 3'b000);
    chk("idle_done", req_done, 0);
    chk("idle_grant", grant, 0);
  endtask

  task automatic randomize_reqs(input int max_len);
    for (int i = 0; i < N; i++) begin
      m_addr[i] = $urandom;
      m_len[i]  = 8'($urandom_range(0, max_len));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    logic [1:0] br;
    int bid;
    resetn = 1'b0;
    req = '0;
    AWREADY = 1'b0;
    dc_data_sent = 1'b0;
    dc_done = 1'b0;
    BID = '0;
    BRESP = '0;
    BVALID = 1'b0;
    randomize_reqs(4);
    pack();
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    chk("post_reset_state", state_out, 3'b000);

    // Basic burst: delayed AWREADY, four beats, OKAY.
    m_addr[0] = 32'h1000;
    m_len[0]  = 8'd3;
    run_burst(2'b01, 2, 0, -1, 2'b00, 0, 0, 0);

    // Both requesters held: strict alternation.
    for (int k = 0; k < 4; k++) begin
      randomize_reqs(4);
      run_burst(2'b11, $urandom_range(0, 3), $urandom_range(0, 2), -1, 2'b00, 0, 0, 0);
    end

    // Single-beat burst.
    randomize_reqs(4);
    m_len[1] = 8'd0;
    run_burst(2'b10, 0, 1, -1, 2'b00, 0, 0, 0);

    // Error responses: SLVERR, ID mismatch, DECERR.
    randomize_reqs(3);
    run_burst(2'b01, 1, 0, -1, 2'b10, 0, 0, 0);
    run_burst(2'b01, 0, 2, 1, 2'b00, 0, 0, 0);
    run_burst(2'b10, 0, 0, -1, 2'b11, 0, 0, 0);

    // Request dropped mid-burst, then dc_done held high into DONE.
    randomize_reqs(3);
    run_burst(2'b11, 1, 0, -1, 2'b00, 1, 0, 0);
    run_burst(2'b11, 0, 0, -1, 2'b00, 0, 3, 0);

    // Random traffic.
    for (int k = 0; k < 16; k++) begin
      randomize_reqs(5);
      rq  = 2'($urandom_range(1, 3));
      br  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bid = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_burst(rq, $urandom_range(0, 3), $urandom_range(0, 3), bid, br, 0,
                $urandom_range(0, 1), 0);
    end

    // Reset in DATA after two beats: no completion, fresh start from requester 0.
    randomize_reqs(0);
    m_len[0] = 8'd5;
    m_len[1] = 8'd5;
    req = 2'b11;
    pack();
    step();
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    chk("rst_pre_state", state_out, 3'b010);
    dc_data_sent = 1'b1;
    step();
    step();
    dc_data_sent = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    req = '0;
    step();
    chk("rst_hold_done", req_done, 0);
    chk("rst_hold_state", state_out, 3'b000);
    resetn = 1'b1;
    rr_next = 0;
    step();
    chk("rst_rel_done", req_done, 0);
    randomize_reqs(3);
    run_burst(2'b11, 0, 0, -1, 2'b00, 0, 0, 0);

`ifdef AXI_WR_SEQ_TIMEOUT_EN
    randomize_reqs(2);
    run_burst(2'b01, 0, 0, -1, 2'b00, 0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
